usbfs_in_arb: RTL and testbench
===============================

# usbfs_in_arb

Sequencer that shares the USB full-speed transactor's single IN (device-to-host) transmit path among `N_ENDP` IN endpoint transmit buffers. It sits between the transactor and an array of IN endpoints. On each IN token it selects the addressed endpoint and decides the DATA/NAK/STALL response. During the DATA phase it multiplexes that endpoint's write-buffer interface onto the transactor. It tracks the DATA0/DATA1 toggle per endpoint and forwards the host ACK back to the selected endpoint.

## Interface
Parameters:
- `N_ENDP`, 4: number of IN endpoints (1..16); endpoint numbers 0..N_ENDP-1.
- `MAX_PKT`, 8: max packet bytes, power of 2; `IDX_W = $clog2(MAX_PKT)`.

Ports (clock, reset first):
- `i_clk`  in  1  sole clock; all state updates on rising edge.
- `i_rstn`  in  1  reset, asynchronous assert, active-low.
- `i_tokenValid`  in  1  one-cycle pulse: IN token addressed to this device decoded.
- `i_tokenEndp`  in  4  endpoint number of that token; valid with `i_tokenValid`.
- `i_txAccepted`  in  1  pulse: transactor has sent the DATA PID byte.
- `i_txDone`  in  1  pulse: transactor has finished sending the DATA packet (CRC sent).
- `i_hostAck`  in  1  pulse: ACK handshake received from host.
- `i_timeout`  in  1  pulse: handshake timeout or bad handshake.
- `i_clrToggle`  in  N_ENDP  per-endpoint toggle clear (SET_CONFIGURATION, CLEAR_FEATURE).
- `o_respData`  out  1  one-cycle pulse: send DATA packet.
- `o_respNak`  out  1  one-cycle pulse: send NAK.
- `o_respStall`  out  1  one-cycle pulse: send STALL.
- `o_dataPid1`  out  1  1 = DATA1, 0 = DATA0; valid while `o_respData` is high and during SEND.
- `o_busy`  out  1  state != IDLE.
- `o_wrEn`  out  1  muxed write-buffer enable.
- `o_wrIdx`  out  IDX_W  muxed write-buffer index.
- `o_wrByte`  out  8  muxed write-buffer byte.
- `o_etReady`  out  N_ENDP  per-endpoint one-cycle ACK-forward pulse.
- `o_etTxAccepted`  out  N_ENDP  per-endpoint PID-sent pulse.
- `i_etValid`  in  N_ENDP  endpoint has data.
- `i_etStall`  in  N_ENDP  endpoint halted.
- `i_etWrEn`  in  N_ENDP  endpoint write enables.
- `i_etWrIdx`  in  N_ENDP*IDX_W  packed; endpoint k occupies `[k*IDX_W +: IDX_W]`.
- `i_etWrByte`  in  N_ENDP*8  packed; endpoint k occupies `[k*8 +: 8]`.

## Operation
- State machine states: IDLE, RESP, SEND, WAIT_HS. Other registers: `sel` (4 bits) and `toggle[N_ENDP]`.
- **IDLE**
  - On `i_tokenValid`, latch `sel <= i_tokenEndp` and go to RESP.
  - A token with `i_tokenEndp >= N_ENDP` still goes to RESP and is treated as a stalled endpoint.
- **RESP** (exactly one cycle). Priority, evaluated this cycle:
  - Invalid endpoint or `i_etStall[sel]`: pulse `o_respStall`, go to IDLE.
  - Else `i_etValid[sel]`: pulse `o_respData` with `o_dataPid1 = toggle[sel]`, go to SEND.
  - Else: pulse `o_respNak`, go to IDLE.
- **SEND**
  - `o_etTxAccepted[sel] = i_txAccepted`; all other bits are 0.
  - `o_wrEn = i_etWrEn[sel]`, `o_wrIdx = i_etWrIdx[sel]`, `o_wrByte = i_etWrByte[sel]`.
  - On `i_txDone`, go to WAIT_HS.
  - `i_timeout` in SEND: go to IDLE, toggle unchanged.
- **WAIT_HS**
  - `i_hostAck`: pulse `o_etReady[sel]` for one cycle, flip `toggle[sel]`, go to IDLE.
  - `i_timeout`: go to IDLE, toggle unchanged; the host retries with the same PID.
  - `i_hostAck` and `i_timeout` in the same cycle: ACK wins.
- Write-bus gating: outside SEND, `o_wrEn`, `o_wrIdx`, `o_wrByte` and `o_etTxAccepted` are all 0.
- `i_tokenValid` outside IDLE is ignored; it causes no state change.
- Toggle clear:
  - `i_clrToggle[k]` forces `toggle[k] <= 0` in any state.
  - Clear and ACK-flip on the same k in the same cycle: clear wins (result 0).
  - Clear does not abort an in-progress transaction.
- Outside RESP, `o_dataPid1` is `toggle[sel]` in SEND and 0 otherwise.

## Timing
- Reset (`i_rstn` low, asynchronous) forces:
  - state = IDLE, `sel` = 0, all toggles = 0.
  - Every output = 0, including `o_busy`.
- Reset mid-transaction: abandon it immediately; toggles return to 0; no `o_etReady` pulse.
- Response latency: token accepted at cycle T; exactly one of `o_respData`/`o_respNak`/`o_respStall` is high at T+1 and low at T+2.
- `o_busy` is high from T+1 until the cycle after the transition back to IDLE (state-decoded).
- The write mux is combinational on `sel` and is registered nowhere; the `i_etWrEn` to `o_wrEn` path has zero latency in SEND.
- `o_etReady[sel]` is high in the same cycle that `i_hostAck` is seen in WAIT_HS.
- `toggle[sel]` shows its new value from the next cycle onward.
- Minimum token-to-token turnaround: NAK/STALL 2 cycles; DATA is bounded by the transactor pulses.
- All response, enable and pulse outputs are at most one-hot across endpoints at all times.

## Test plan
- Reset, then token endp=1 with `i_etValid=4'b0010`:
  - `o_respData` at T+1 with `o_dataPid1=0`.
  - Bytes on `i_etWrByte[1]` (0xA5, 0x5A at idx 0, 1) appear on `o_wrByte`/`o_wrIdx` with `o_wrEn`.
  - `i_txDone`, then `i_hostAck` gives `o_etReady=4'b0010` for one cycle; next DATA to endp 1 has PID1.
- Token endp=2 with `i_etValid[2]=0`: `o_respNak` one cycle, back to IDLE, no toggle change.
- `i_etStall[3]=1` with `i_etValid[3]=1`: `o_respStall`, not data. Token endp=9 with `N_ENDP=4`: `o_respStall`.
- DATA to endp 0, then `i_timeout` in WAIT_HS: no `o_etReady`; retry token gives DATA0 again. ACK and timeout in the same cycle: ACK taken, toggle flips.
- `i_clrToggle[0]` in the same cycle as `i_hostAck` for endp 0 (toggle=0→would be 1): toggle reads 0. A token arriving during SEND is ignored.
- Assert `i_rstn` low during SEND with `o_wrEn` high: all outputs 0 immediately, toggles 0. After release, a token gets a normal response at T+1.

Source files
------------

// File: rtl/usbfs_in_arb.sv
// Shares the USB FS transactor's single IN transmit path among N_ENDP IN endpoints:
// per-token DATA/NAK/STALL decision, write-buffer mux during SEND, DATA0/1 toggle tracking.
module usbfs_in_arb #(
  parameter int unsigned N_ENDP  = 4,
  parameter int unsigned MAX_PKT = 8,
  localparam int unsigned IDX_W  = $clog2(MAX_PKT)
) (
  input  logic                      i_clk,
  input  logic                      i_rstn,
  input  logic                      i_tokenValid,
  input  logic [3:0]                i_tokenEndp,
  input  logic                      i_txAccepted,
  input  logic                      i_txDone,
  input  logic                      i_hostAck,
  input  logic                      i_timeout,
  input  logic [N_ENDP-1:0]         i_clrToggle,
  output logic                      o_respData,
  output logic                      o_respNak,
  output logic                      o_respStall,
  output logic                      o_dataPid1,
  output logic                      o_busy,
  output logic                      o_wrEn,
  output logic [IDX_W-1:0]          o_wrIdx,
  output logic [7:0]                o_wrByte,
  output logic [N_ENDP-1:0]         o_etReady,
  output logic [N_ENDP-1:0]         o_etTxAccepted,
  input  logic [N_ENDP-1:0]         i_etValid,
  input  logic [N_ENDP-1:0]         i_etStall,
  input  logic [N_ENDP-1:0]         i_etWrEn,
  input  logic [N_ENDP*IDX_W-1:0]   i_etWrIdx,
  input  logic [N_ENDP*8-1:0]       i_etWrByte
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESP    = 2'd1,
    SEND    = 2'd2,
    WAIT_HS = 2'd3
  } state_t;

  state_t              state, state_d;
  logic [3:0]          sel, sel_d;
  logic [N_ENDP-1:0]   toggle, toggle_d;

  // One-hot decode of sel; all zero when the token addressed a nonexistent endpoint.
  logic [N_ENDP-1:0]   sel_oh;
  logic                sel_stall;
  logic                sel_valid;
  logic                sel_toggle;
  logic                sel_wr_en;
  logic [IDX_W-1:0]    sel_wr_idx;
  logic [7:0]          sel_wr_byte;
  logic                ep_ok;

  always_comb begin
    sel_oh      = '0;
    sel_stall   = 1'b0;
    sel_valid   = 1'b0;
    sel_toggle  = 1'b0;
    sel_wr_en   = 1'b0;
    sel_wr_idx  = '0;
    sel_wr_byte = '0;
    for (int k = 0; k < int'(N_ENDP); k++) begin
      if (sel == 4'(k)) begin
        sel_oh[k]   = 1'b1;
        sel_stall   = i_etStall[k];
        sel_valid   = i_etValid[k];
        sel_toggle  = toggle[k];
        sel_wr_en   = i_etWrEn[k];
        sel_wr_idx  = i_etWrIdx[k*IDX_W +: IDX_W];
        sel_wr_byte = i_etWrByte[k*8 +: 8];
      end
    end
    ep_ok = |sel_oh;
  end

  // State, endpoint select and toggle registers.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state  <= IDLE;
      sel    <= 4'd0;
      toggle <= '0;
    end else begin
      state  <= state_d;
      sel    <= sel_d;
      toggle <= toggle_d;
    end
  end

  // Next-state and output decode; responses and pulses follow the current state directly.
  always_comb begin
    state_d        = state;
    sel_d          = sel;
    toggle_d       = toggle;
    o_respData     = 1'b0;
    o_respNak      = 1'b0;
    o_respStall    = 1'b0;
    o_dataPid1     = 1'b0;
    o_busy         = (state != IDLE);
    o_wrEn         = 1'b0;
    o_wrIdx        = '0;
    o_wrByte       = '0;
    o_etReady      = '0;
    o_etTxAccepted = '0;

    unique case (state)
      IDLE: begin
        if (i_tokenValid) begin
          sel_d   = i_tokenEndp;
          state_d = RESP;
        end
      end
      RESP: begin
        if (!ep_ok || sel_stall) begin
          o_respStall = 1'b1;
          state_d     = IDLE;
        end else if (sel_valid) begin
          o_respData  = 1'b1;
          o_dataPid1  = sel_toggle;
          state_d     = SEND;
        end else begin
          o_respNak   = 1'b1;
          state_d     = IDLE;
        end
      end
      SEND: begin
        o_dataPid1     = sel_toggle;
        o_wrEn         = sel_wr_en;
        o_wrIdx        = sel_wr_idx;
        o_wrByte       = sel_wr_byte;
        o_etTxAccepted = i_txAccepted ? sel_oh : '0;
        // An aborted packet leaves the toggle alone so the retry reuses the PID.
        if (i_timeout) begin
          state_d = IDLE;
        end else if (i_txDone) begin
          state_d = WAIT_HS;
        end
      end
      WAIT_HS: begin
        if (i_hostAck) begin
          o_etReady = sel_oh;
          toggle_d  = toggle ^ sel_oh;
          state_d   = IDLE;
        end else if (i_timeout) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Toggle clear overrides any ACK flip in the same cycle.
    toggle_d = toggle_d & ~i_clrToggle;
  end

endmodule

// File: tb/tb_usbfs_in_arb.sv
// Directed table-driven bench for usbfs_in_arb (N_ENDP=4, MAX_PKT=8), plus a reset-during-SEND sequence.
module tb_usbfs_in_arb;

  localparam int unsigned N_ENDP  = 4;
  localparam int unsigned MAX_PKT = 8;
  localparam int unsigned IDX_W   = 3;

  logic                    clk;
  logic                    rstn;
  logic                    token_valid;
  logic [3:0]              token_endp;
  logic                    tx_accepted;
  logic                    tx_done;
  logic                    host_ack;
  logic                    timeout;
  logic [N_ENDP-1:0]       clr_toggle;
  logic                    resp_data;
  logic                    resp_nak;
  logic                    resp_stall;
  logic                    data_pid1;
  logic                    busy;
  logic                    wr_en;
  logic [IDX_W-1:0]        wr_idx;
  logic [7:0]              wr_byte;
  logic [N_ENDP-1:0]       et_ready;
  logic [N_ENDP-1:0]       et_tx_accepted;
  logic [N_ENDP-1:0]       et_valid;
  logic [N_ENDP-1:0]       et_stall;
  logic [N_ENDP-1:0]       et_wr_en;
  logic [N_ENDP*IDX_W-1:0] et_wr_idx;
  logic [N_ENDP*8-1:0]     et_wr_byte;

  usbfs_in_arb #(.N_ENDP(N_ENDP), .MAX_PKT(MAX_PKT)) dut (
    .i_clk          (clk),
    .i_rstn         (rstn),
    .i_tokenValid   (token_valid),
    .i_tokenEndp    (token_endp),
    .i_txAccepted   (tx_accepted),
    .i_txDone       (tx_done),
    .i_hostAck      (host_ack),
    .i_timeout      (timeout),
    .i_clrToggle    (clr_toggle),
    .o_respData     (resp_data),
    .o_respNak      (resp_nak),
    .o_respStall    (resp_stall),
    .o_dataPid1     (data_pid1),
    .o_busy         (busy),
    .o_wrEn         (wr_en),
    .o_wrIdx        (wr_idx),
    .o_wrByte       (wr_byte),
    .o_etReady      (et_ready),
    .o_etTxAccepted (et_tx_accepted),
    .i_etValid      (et_valid),
    .i_etStall      (et_stall),
    .i_etWrEn       (et_wr_en),
    .i_etWrIdx      (et_wr_idx),
    .i_etWrByte     (et_wr_byte)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {respData,respNak,respStall,pid1,busy,wrEn,wrIdx[3],wrByte[8],etReady[4],etTxAcc[4]}
  logic [24:0] got;
  assign got = {resp_data, resp_nak, resp_stall, data_pid1, busy, wr_en, wr_idx, wr_byte,
                et_ready, et_tx_accepted};

  typedef struct packed {
    logic        tv;
    logic [3:0]  te;
    logic        txa;
    logic        txd;
    logic        ack;
    logic        to;
    logic [3:0]  clr;
    logic [3:0]  valid;
    logic [3:0]  stall;
    logic [3:0]  wen;
    logic [11:0] widx;
    logic [31:0] wbyte;
    logic [24:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [24:0] ex(input logic rd, input logic rn, input logic rs,
                                     input logic pid, input logic bsy, input logic wen,
                                     input logic [2:0] idx, input logic [7:0] byt,
                                     input logic [3:0] rdy, input logic [3:0] txacc);
    return {rd, rn, rs, pid, bsy, wen, idx, byt, rdy, txacc};
  endfunction

  function automatic vec_t mk(input logic tv, input logic [3:0] te, input logic txa,
                              input logic txd, input logic ack, input logic to,
                              input logic [3:0] clr, input logic [3:0] valid,
                              input logic [3:0] stall, input logic [3:0] wen,
                              input logic [11:0] widx, input logic [31:0] wbyte,
                              input logic [24:0] e);
    vec_t v;
    v.tv = tv; v.te = te; v.txa = txa; v.txd = txd; v.ack = ack; v.to = to;
    v.clr = clr; v.valid = valid; v.stall = stall; v.wen = wen;
    v.widx = widx; v.wbyte = wbyte; v.exp = e;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    token_valid = v.tv;  token_endp = v.te;  tx_accepted = v.txa; tx_done = v.txd;
    host_ack = v.ack;    timeout = v.to;     clr_toggle = v.clr;  et_valid = v.valid;
    et_stall = v.stall;  et_wr_en = v.wen;   et_wr_idx = v.widx;  et_wr_byte = v.wbyte;
  endtask

  task automatic check(input string name, input logic [24:0] e);
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s got=%07h exp=%07h", name, got, e);
    end
  endtask

  task automatic apply(input vec_t v, input string name);
    @(negedge clk);
    drive(v);
    #1;
    check(name, v.exp);
  endtask

  localparam logic [24:0] Z = 25'd0;

  initial begin
    // Row table: one entry per clock cycle.
    vecs.push_back(mk(1,4'd1,0,0,0,0,4'b0000,4'b0010,4'b0000,4'b0000,12'h000,32'h0, Z));
    vecs.push_back(mk(0,4'd0,0,0,0,0,4'b0000,4'b0010,4'b0000,4'b0000,12'h000,32'h0, ex(1,0,0,0,1,0,3'd0,8'h00,4'b0000,4'b0000)));
    vecs.push_back(mk(0,4'd0,0,0,0,0,4'b0000,4'b0000,4'b0000,4'b0011,12'h007,32'h0000A5FF, ex(0,0,0,0,1,1,3'd0,8'hA5,4'b0000,4'b0000)));
    vecs.push_back(mk(0,4'd0,1,0,0,0,4'b0000,4'b0000,4'b0000,4'b0010,12'h008,32'h00005A00, ex(0,0,0,0,1,1,3'd1,8'h5A,4'b0000,4'b0010)));
    vecs.push_back(mk(0,4'd0,0,1,0,0,4'b0000,4'b0000,4'b0000,4'b0000,12'h000,32'h0, ex(0,0,0,0,1,0,3'd0,8'h00,4'b0000,4'b0000)));
    vecs.push_back(mk(0,4'd0,0,0,1,0,4'b0000,4'b0000,4'b0000,4'b0000,12'h000,32'h0, ex(0,0,0,0,1,0,3'd0,8'h00,4'b0010,4'b0000)));
    vecs.push_back(mk(0,4'd0,0,0,0,0,4'b0000,4'b0000,4'b0000,4'b0000,12'h000,32'h0, Z));
    // Second DATA to endp 1 uses DATA1, then aborted by timeout in SEND.
    vecs.push_back(mk(1,4'd1,0,0,0,0,4'b0000,4'b0010,4'b0000,4'b0000,12'h000,32'h0, Z));
    vecs.push_back(mk(0,4'd0,0,0,0,0,4'b0000,4'b0010,4'b0000,4'b0000,12'h000,32'h0, ex(1,0,0,1,1,0,3'd0,8'h00,4'b0000,4'b0000)));
    vecs.push_back(mk(0,4'd0,0,0,0,1,4'b0000,4'b0000,4'b0000,4'b0000,12'h000,32'h0, ex(0,0,0,1,1,0,3'd0,8'h00,4'b0000,4'b0000)));
    // NAK on endp 2.
    vecs.push_back(mk(1,4'd2,0,0,0,0,4'b0000,4'b0010,4'b0000,4'b0000,12'h000,32'h0, Z));
    vecs.push_back(mk(0,4'd0,0,0,0,0,4'b0000,4'b0010,4'b0000,4'b0000,12'h000,32'h0, ex(0,1,0,0,1,0,3'd0,8'h00,4'b0000,4'b0000)));
    vecs.push_back(mk(0,4'd0,0,0,0,0,4'b0000,4'b0000,4'b0000,4'b0000,12'h000,32'h0, Z));
    // STALL beats valid on endp 3; endp 9 is out of range.
    vecs.push_back(mk(1,4'd3,0,0,0,0,4'b0000,4'b1000,4'b1000,4'b0000,12'h000,32'h0, Z));
    vecs.push_back(mk(0,4'd0,0,0,0,0,4'b0000,4'b1000,4'b1000,4'b0000,12'h000,32'h0, ex(0,0,1,0,1,0,3'd0,8'h00,4'b0000,4'b0000)));
    vecs.push_back(mk(1,4'd9,0,0,0,0,4'b0000,4'b1111,4'b0000,4'b0000,12'h000,32'h0, Z));
    vecs.push_back(mk(0,4'd0,0,0,0,0,4'b0000,4'b1111,4'b0000,4'b0000,12'h000,32'h0, ex(0,0,1,0,1,0,3'd0,8'h00,4'b0000,4'b0000)));
    // Endp 0: timeout in WAIT_HS, retry DATA0, then ACK+timeout together.
    vecs.push_back(mk(1,4'd0,0,0,0,0,4'b0000,4'b0001,4'b0000,4'b0000,12'h000,32'h0, Z));
    vecs.push_back(mk(0,4'd0,0,0,0,0,4'b0000,4'b0001,4'b0000,4'b0000,12'h000,32'h0, ex(1,0,0,0,1,0,3'd0,8'h00,4'b0000,4'b0000)));
    vecs.push_back(mk(0,4'd0,0,1,0,0,4'b0000,4'b0000,4'b0000,4'b0000,12'h000,32'h0, ex(0,0,0,0,1,0,3'd0,8'h00,4'b0000,4'b0000)));
    vecs.push_back(mk(0,4'd0,0,0,0,1,4'b0000,4'b0000,4'b0000,4'b0000,12'h000,32'h0, ex(0,0,0,0,1,0,3'd0,8'h00,4'b0000,4'b0000)));
    vecs.push_back(mk(1,4'd0,0,0,0,0,4'b0000,4'b0001,4'b0000,4'b0000,12'h000,32'h0, Z));
    vecs.push_back(mk(0,4'd0,0,0,0,0,4'b0000,4'b0001,4'b0000,4'b0000,12'h000,32'h0, ex(1,0,0,0,1,0,3'd0,8'h00,4'b0000,4'b0000)));
    vecs.push_back(mk(0,4'd0,0,1,0,0,4'b0000,4'b0000,4'b0000,4'b0000,12'h000,32'h0, ex(0,0,0,0,1,0,3'd0,8'h00,4'b0000,4'b0000)));
    vecs.push_back(mk(0,4'd0,0,0,1,1,4'b0000,4'b0000,4'b0000,4'b0000,12'h000,32'h0, ex(0,0,0,0,1,0,3'd0,8'h00,4'b0001,4'b0000)));
    // Endp 0 now DATA1; clear during SEND, then ACK with clear: toggle stays 0.
    vecs.push_back(mk(1,4'd0,0,0,0,0,4'b0000,4'b0001,4'b0000,4'b0000,12'h000,32'h0, Z));
    vecs.push_back(mk(0,4'd0,0,0,0,0,4'b0000,4'b0001,4'b0000,4'b0000,12'h000,32'h0, ex(1,0,0,1,1,0,3'd0,8'h00,4'b0000,4'b0000)));
    vecs.push_back(mk(0,4'd0,0,1,0,0,4'b0001,4'b0000,4'b0000,4'b0000,12'h000,32'h0, ex(0,0,0,1,1,0,3'd0,8'h00,4'b0000,4'b0000)));
    vecs.push_back(mk(0,4'd0,0,0,1,0,4'b0001,4'b0000,4'b0000,4'b0000,12'h000,32'h0, ex(0,0,0,0,1,0,3'd0,8'h00,4'b0001,4'b0000)));
    vecs.push_back(mk(1,4'd0,0,0,0,0,4'b0000,4'b0001,4'b0000,4'b0000,12'h000,32'h0, Z));
    vecs.push_back(mk(0,4'd0,0,0,0,0,4'b0000,4'b0001,4'b0000,4'b0000,12'h000,32'h0, ex(1,0,0,0,1,0,3'd0,8'h00,4'b0000,4'b0000)));
    // Token during SEND is ignored; write mux follows endp 0.
    vecs.push_back(mk(1,4'd2,0,0,0,0,4'b0000,4'b0100,4'b0000,4'b0001,12'h003,32'h0000003C, ex(0,0,0,0,1,1,3'd3,8'h3C,4'b0000,4'b0000)));
    vecs.push_back(mk(0,4'd0,0,1,0,0,4'b0000,4'b0000,4'b0000,4'b0000,12'h000,32'h0, ex(0,0,0,0,1,0,3'd0,8'h00,4'b0000,4'b0000)));
    vecs.push_back(mk(0,4'd0,0,0,0,1,4'b0000,4'b0000,4'b0000,4'b0000,12'h000,32'h0, ex(0,0,0,0,1,0,3'd0,8'h00,4'b0000,4'b0000)));
    vecs.push_back(mk(0,4'd0,0,0,0,0,4'b0000,4'b0000,4'b0000,4'b0000,12'h000,32'h0, Z));
    // Endp 1 toggle still 1 before the reset sequence.
    vecs.push_back(mk(1,4'd1,0,0,0,0,4'b0000,4'b0010,4'b0000,4'b0000,12'h000,32'h0, Z));
    vecs.push_back(mk(0,4'd0,0,0,0,0,4'b0000,4'b0010,4'b0000,4'b0000,12'h000,32'h0, ex(1,0,0,1,1,0,3'd0,8'h00,4'b0000,4'b0000)));

    // Reset state.
    drive(mk(0,4'd0,0,0,0,0,4'b0000,4'b0000,4'b0000,4'b0000,12'h000,32'h0, Z));
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", Z);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], $sformatf("row%0d", i));
    end

    // Reset asserted mid-SEND with the write enable high.
    apply(mk(0,4'd0,0,0,0,0,4'b0000,4'b0000,4'b0000,4'b0010,12'h000,32'h00007700,
             ex(0,0,0,1,1,1,3'd0,8'h77,4'b0000,4'b0000)), "send_before_rst");
    rstn = 1'b0;
    #1;
    check("rst_mid_send", Z);
    host_ack = 1'b1;
    @(posedge clk);
    #1;
    check("rst_hold_ack", Z);
    @(negedge clk);
    rstn = 1'b1;
    apply(mk(1,4'd1,0,0,0,0,4'b0000,4'b0010,4'b0000,4'b0000,12'h000,32'h0, Z), "post_rst_token");
    apply(mk(0,4'd0,0,0,0,0,4'b0000,4'b0010,4'b0000,4'b0000,12'h000,32'h0,
             ex(1,0,0,0,1,0,3'd0,8'h00,4'b0000,4'b0000)), "post_rst_data0");
    apply(mk(0,4'd0,0,0,0,1,4'b0000,4'b0000,4'b0000,4'b0000,12'h000,32'h0,
             ex(0,0,0,0,1,0,3'd0,8'h00,4'b0000,4'b0000)), "post_rst_abort");
    apply(mk(0,4'd0,0,0,0,0,4'b0000,4'b0000,4'b0000,4'b0000,12'h000,32'h0, Z), "post_rst_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
